cash_dispenser: RTL and testbench
=================================

# cash_dispenser

Downstream stage of the ATM controller. On a withdraw request it splits the requested amount into notes of 100/50/20/10 (largest first, limited by cassette stock). It then feeds the notes one at a time to the note-feeder mechanism over a req/ack handshake and reports completion, rejection or a jam. Cassette stock counts are held internally and reloaded by a refill strobe.

## Interface
- AMT_W, 16, width of amount and dispensed-total buses
- CNT_W, 8, width of each cassette note counter
- INIT_NOTES, 10, per-cassette count loaded on reset and refill
- LOW_MARK, 3, low_stock threshold
- ACK_TIMEOUT, 15, cycles note_req may stay unacknowledged before jam
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- dispense_req  input  1  one-cycle withdraw request (driven from Withdrawed_Successfully)
- amount  input  AMT_W  requested amount, sampled with dispense_req
- refill  input  1  one-cycle cassette reload strobe
- note_ack  input  1  feeder accepted the current note
- note_req  output  1  feeder request, one note per handshake
- note_sel  output  2  cassette selected: 0=100, 1=50, 2=20, 3=10
- busy  output  1  high from accepted request until done/reject/jam
- done  output  1  one-cycle pulse, all notes delivered
- reject  output  1  one-cycle pulse, request refused, no notes fed
- jam  output  1  sticky level, feeder timeout
- dispensed  output  AMT_W  sum of acknowledged notes in current or last transaction
- low_stock  output  4  bit k high when cassette k count < LOW_MARK

## Operation
- Reset values:
  - note_req, note_sel, busy, done, reject, jam, dispensed: all 0.
  - All four counts = INIT_NOTES.
- States: IDLE, PLAN, CHECK, FEED, WAIT_ACK, JAM.
- IDLE:
  - dispense_req latches amount, clears dispensed, sets busy, and goes to PLAN.
  - refill reloads counts.
  - If dispense_req and refill arrive together, refill wins and the request is dropped silently.
- PLAN: four cycles, one per denomination d in order 100, 50, 20, 10.
  - n_d = min(rem / d, count_d).
  - rem -= n_d*d.
  - Counts are not modified yet.
- CHECK:
  - amount==0 or rem!=0 → reject pulse, busy low, IDLE, counts unchanged.
  - Otherwise → FEED.
- Greedy only. No backtracking search.
- FEED:
  - Selects the next planned note, largest denomination first.
  - Drives note_req=1 and note_sel, then goes to WAIT_ACK.
- WAIT_ACK:
  - On note_ack: decrement that cassette count, dispensed += d, drop note_req.
  - If notes remain, return to FEED. Otherwise pulse done, drop busy, go to IDLE.
- note_ack while note_req=0 is ignored.
- dispense_req while busy is ignored: no reject, amount not relatched.
- JAM:
  - jam=1, busy=0, note_req=0.
  - dispense_req → reject pulse.
  - refill reloads counts, clears jam, goes to IDLE.
- dispensed holds its value after done/jam until the next accepted request.
- Arithmetic is unsigned. Counts never underflow, because planning is bounded by them.

## Timing
- dispense_req sampled at edge E. PLAN occupies E+1..E+4, CHECK is E+5.
- reject or first note_req is visible after edge E+6.
- note_req stays high until the edge that samples note_ack, then is low for one cycle before the next note.
  - Minimum 2 cycles per note with an immediate ack.
- done asserts the cycle after the final ack edge.
- Counts and dispensed update on the ack edge.
- low_stock is combinational from the counts.
- Reset mid-transaction: immediate return to reset values. Notes already acked are not restored to the counts; the counts reload to INIT_NOTES.

## Configuration
- CASH_DISPENSER_JAM_TIMEOUT_EN
- Defined:
  - A timer counts cycles with note_req=1 and no ack, and clears on ack.
  - When the timer reaches ACK_TIMEOUT, the block enters JAM: note_req drops and jam rises. The note is not counted.
- Undefined:
  - No timer. WAIT_ACK waits indefinitely.
  - JAM state and the jam output are tied to 0. refill works in IDLE only.

## Test plan
- Reset, INIT_NOTES=10, amount=380:
  - note_sel sequence 0,0,0,1,2,3.
  - done pulse, dispensed=380.
  - Counts 7/9/9/9.
- amount=35, then amount=0:
  - Each gives a reject pulse at E+6.
  - note_req never asserts, counts unchanged.
- INIT_NOTES=2, amount=500:
  - Plan 200+100+40+20, rem=140 → reject.
  - Counts stay 2/2/2/2, low_stock=4'b1111 with LOW_MARK=3.
- JAM_TIMEOUT_EN, amount=200:
  - Ack first note, hold note_ack low 15 cycles → jam=1, dispensed=100, count_100=INIT_NOTES-1.
  - New dispense_req → reject.
  - refill → jam=0, counts reload.
- amount=60 with immediate acks:
  - Extra dispense_req and spurious note_ack while note_req=0 are both ignored.
  - Notes are 50 then 10, dispensed=60.
- Assert reset during the second note of amount=300:
  - All outputs return to 0 and counts return to INIT_NOTES.
  - A following amount=100 completes normally.

Source files
------------

// File: rtl/cash_dispenser.sv
// Note dispenser: greedy 100/50/20/10 planning against cassette stock, then one-note-at-a-time req/ack feeding.
// Optional feeder-jam timeout enabled by defining CASH_DISPENSER_JAM_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | waiting for a withdraw request or refill
// S_PLAN   | one denomination per cycle, 100 first
// S_CHECK  | accept the plan or refuse the request
// S_FEED   | pick the next planned note
// S_WAIT_ACK | note_req high, waiting for the feeder
// S_JAM    | feeder timed out, waiting for refill
module cash_dispenser #(
   parameter int AMT_W       = 16,
   parameter int CNT_W       = 8,
   parameter int INIT_NOTES  = 10,
   parameter int LOW_MARK    = 3,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_dispense_req,
   input  logic [AMT_W-1:0] i_amount,
   input  logic             i_refill,
   input  logic             i_note_ack,
   output logic             o_note_req,
   output logic [1:0]       o_note_sel,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_reject,
   output logic             o_jam,
   output logic [AMT_W-1:0] o_dispensed,
   output logic [3:0]       o_low_stock
);

   typedef enum logic [2:0] {
      S_IDLE, S_PLAN, S_CHECK, S_FEED, S_WAIT_ACK, S_JAM
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [AMT_W-1:0] r_rem;
   logic             r_amt_zero;
   logic [1:0]       r_idx;
   logic [CNT_W-1:0] r_n   [4];
   logic [CNT_W-1:0] r_cnt [4];
   logic [1:0]       r_sel;
   logic [AMT_W-1:0] r_disp;
   logic             r_done;
   logic             r_reject;
   logic             r_rej_arm;

   logic [AMT_W-1:0] w_quot;
   logic [AMT_W-1:0] w_den;
   logic [AMT_W-1:0] w_cnt_ext;
   logic [AMT_W-1:0] w_take;
   logic [1:0]       w_pick;
   logic             w_more;
   logic             w_plan_bad;
   logic             w_accept, w_reload, w_plan_step, w_rej_arm, w_rej_set;
   logic             w_feed, w_ack_take, w_done_set;

`ifdef CASH_DISPENSER_JAM_TIMEOUT_EN
   localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   logic [TMR_W-1:0] r_tmr;
`endif

   function automatic logic [AMT_W-1:0] f_denom(input logic [1:0] sel);
      case (sel)
         2'd0:    f_denom = AMT_W'(100);
         2'd1:    f_denom = AMT_W'(50);
         2'd2:    f_denom = AMT_W'(20);
         default: f_denom = AMT_W'(10);
      endcase
   endfunction

   // constant divisors per step keep the divider trivial
   always_comb begin
      w_quot = '0;
      case (r_idx)
         2'd0:    w_quot = r_rem / AMT_W'(100);
         2'd1:    w_quot = r_rem / AMT_W'(50);
         2'd2:    w_quot = r_rem / AMT_W'(20);
         default: w_quot = r_rem / AMT_W'(10);
      endcase
      w_den     = f_denom(r_idx);
      w_cnt_ext = AMT_W'(r_cnt[r_idx]);
      w_take    = (w_quot < w_cnt_ext) ? w_quot : w_cnt_ext;
   end

   always_comb begin
      w_pick = 2'd3;
      for (int k = 3; k >= 0; k--) begin
         if (r_n[k] != '0) w_pick = 2'(k);
      end
   end

   always_comb begin
      w_more = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (2'(k) == r_sel) begin
            if (r_n[k] > CNT_W'(1)) w_more = 1'b1;
         end else if (r_n[k] != '0) begin
            w_more = 1'b1;
         end
      end
   end

   assign w_plan_bad = r_amt_zero || (r_rem != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_reload    = 1'b0;
      w_plan_step = 1'b0;
      w_rej_arm   = 1'b0;
      w_rej_set   = 1'b0;
      w_feed      = 1'b0;
      w_ack_take  = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_refill) begin
               w_reload = 1'b1;
            end else if (i_dispense_req) begin
               w_accept    = 1'b1;
               w_state_nxt = S_PLAN;
            end
         end
         S_PLAN: begin
            w_plan_step = 1'b1;
            if (r_idx == 2'd3) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            // refusal takes one extra cycle so it lands with the same latency as a first note
            if (!w_plan_bad) begin
               w_state_nxt = S_FEED;
            end else if (r_rej_arm) begin
               w_rej_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_rej_arm = 1'b1;
            end
         end
         S_FEED: begin
            w_feed      = 1'b1;
            w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (i_note_ack) begin
               w_ack_take = 1'b1;
               if (w_more) begin
                  w_state_nxt = S_FEED;
               end else begin
                  w_done_set  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
`ifdef CASH_DISPENSER_JAM_TIMEOUT_EN
            else if (r_tmr == '0) begin
               w_state_nxt = S_JAM;
            end
`endif
         end
         S_JAM: begin
`ifdef CASH_DISPENSER_JAM_TIMEOUT_EN
            if (i_refill) begin
               w_reload    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (i_dispense_req) begin
               w_rej_set = 1'b1;
            end
`else
            w_state_nxt = S_IDLE;
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rem      <= '0;
         r_amt_zero <= 1'b0;
         r_idx      <= '0;
         r_sel      <= '0;
         r_disp     <= '0;
         r_done     <= 1'b0;
         r_reject   <= 1'b0;
         r_rej_arm  <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            r_n[k]   <= '0;
            r_cnt[k] <= CNT_W'(INIT_NOTES);
         end
      end else begin
         r_done   <= w_done_set;
         r_reject <= w_rej_set;
         if (w_reload) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= CNT_W'(INIT_NOTES);
         end
         if (w_accept) begin
            r_rem      <= i_amount;
            r_amt_zero <= (i_amount == '0);
            r_idx      <= '0;
            r_disp     <= '0;
            r_rej_arm  <= 1'b0;
         end
         if (w_plan_step) begin
            r_n[r_idx] <= CNT_W'(w_take);
            r_rem      <= r_rem - w_take * w_den;
            r_idx      <= r_idx + 2'd1;
         end
         if (w_rej_arm) r_rej_arm <= 1'b1;
         if (w_feed)    r_sel     <= w_pick;
         if (w_ack_take) begin
            r_cnt[r_sel] <= r_cnt[r_sel] - CNT_W'(1);
            r_n[r_sel]   <= r_n[r_sel] - CNT_W'(1);
            r_disp       <= r_disp + f_denom(r_sel);
         end
      end
   end

`ifdef CASH_DISPENSER_JAM_TIMEOUT_EN
   // down-counter: reaching zero with no ack means ACK_TIMEOUT unacknowledged cycles
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tmr <= '0;
      end else if (w_feed) begin
         r_tmr <= TMR_W'(ACK_TIMEOUT - 1);
      end else if (r_state == S_WAIT_ACK && !i_note_ack && r_tmr != '0) begin
         r_tmr <= r_tmr - TMR_W'(1);
      end
   end
   assign o_jam = (r_state == S_JAM);
`else
   assign o_jam = 1'b0;
`endif

   assign o_note_req  = (r_state == S_WAIT_ACK);
   assign o_note_sel  = r_sel;
   assign o_busy      = (r_state == S_PLAN) || (r_state == S_CHECK) ||
                        (r_state == S_FEED) || (r_state == S_WAIT_ACK);
   assign o_done      = r_done;
   assign o_reject    = r_reject;
   assign o_dispensed = r_disp;

   always_comb begin
      o_low_stock = '0;
      for (int k = 0; k < 4; k++) begin
         o_low_stock[k] = (r_cnt[k] < CNT_W'(LOW_MARK));
      end
   end

endmodule

// File: tb/tb_cash_dispenser.sv
// Scoreboard bench for cash_dispenser: expected note/done/reject events are queued at request time
// and popped as the DUT produces them. Jam checks run when CASH_DISPENSER_JAM_TIMEOUT_EN is defined.
module tb_cash_dispenser;
   localparam int AMT_W = 16;
   localparam int CNT_W = 8;
   localparam int INIT  = 10;
   localparam int LOWM  = 3;
   localparam int TMO   = 15;

   localparam int EV_NOTE = 0;
   localparam int EV_DONE = 1;
   localparam int EV_REJ  = 2;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             dreq;
   logic [AMT_W-1:0] amount;
   logic             refill;
   logic             note_ack;
   logic             note_req;
   logic [1:0]       note_sel;
   logic             busy, done, reject, jam;
   logic [AMT_W-1:0] dispensed;
   logic [3:0]       low_stock;

   int   n_chk  = 0;
   int   n_pass = 0;
   int   mcnt [4];
   int   den  [4] = '{100, 50, 20, 10};
   ev_t  exp_q[$];

   cash_dispenser #(
      .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_NOTES(INIT), .LOW_MARK(LOWM), .ACK_TIMEOUT(TMO)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_dispense_req(dreq), .i_amount(amount),
      .i_refill(refill), .i_note_ack(note_ack), .o_note_req(note_req), .o_note_sel(note_sel),
      .o_busy(busy), .o_done(done), .o_reject(reject), .o_jam(jam),
      .o_dispensed(dispensed), .o_low_stock(low_stock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, expv);
   endtask

   function automatic int low_exp();
      int r = 0;
      for (int k = 0; k < 4; k++) if (mcnt[k] < LOWM) r |= (1 << k);
      return r;
   endfunction

   task automatic model_reload();
      for (int k = 0; k < 4; k++) mcnt[k] = INIT;
   endtask

   task automatic model_push(input int a);
      int rem = a;
      int n[4];
      for (int k = 0; k < 4; k++) begin
         int q = rem / den[k];
         n[k] = (q < mcnt[k]) ? q : mcnt[k];
         rem -= n[k] * den[k];
      end
      if (a == 0 || rem != 0) begin
         exp_q.push_back('{EV_REJ, 0});
      end else begin
         for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < n[k]; j++) exp_q.push_back('{EV_NOTE, k});
            mcnt[k] -= n[k];
         end
         exp_q.push_back('{EV_DONE, a});
      end
   endtask

   task automatic expect_ev(input string tag, input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_unexpected"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_kind"}, kind, e.kind);
         chk({tag, "_val"}, val, e.val);
      end
   endtask

   task automatic run_txn(input int a, input bit noisy);
      bit prev  = 1'b0;
      bit fin   = 1'b0;
      bit first = 1'b1;
      int k     = 0;
      model_push(a);
      @(negedge clk);
      dreq = 1'b1; amount = AMT_W'(a);
      @(negedge clk);
      dreq = 1'b0;
      chk("busy_hi", busy, 1);
      while (!fin && k < 200) begin
         dreq = 1'b0;
         if (noisy && k == 2) begin
            dreq = 1'b1; amount = AMT_W'(990);
         end
         if (note_req && !prev) begin
            if (first) chk("latency", k, 6);
            first = 1'b0;
            expect_ev("note", EV_NOTE, note_sel);
         end
         if (reject) begin
            if (first) chk("latency", k, 6);
            first = 1'b0;
            expect_ev("reject", EV_REJ, 0);
            fin = 1'b1;
         end
         if (done) begin
            expect_ev("done", EV_DONE, dispensed);
            fin = 1'b1;
         end
         note_ack = note_req ? 1'b1 : (noisy && (k % 3 == 0));
         prev = note_req;
         @(negedge clk);
         k++;
      end
      if (!fin) chk("txn_timeout", 0, 1);
      note_ack = 1'b0; dreq = 1'b0;
      chk("sb_drain", exp_q.size(), 0);
      exp_q.delete();
      chk("busy_end", busy, 0);
      chk("low_stock", low_stock, low_exp());
   endtask

   task automatic do_refill();
      @(negedge clk); refill = 1'b1;
      @(negedge clk); refill = 1'b0;
      model_reload();
      chk("refill_low", low_stock, low_exp());
   endtask

   task automatic collide();
      int seen = 0;
      @(negedge clk); refill = 1'b1; dreq = 1'b1; amount = AMT_W'(100);
      @(negedge clk); refill = 1'b0; dreq = 1'b0;
      model_reload();
      for (int i = 0; i < 10; i++) begin
         if (busy || note_req || reject || done) seen++;
         @(negedge clk);
      end
      chk("collide_quiet", seen, 0);
   endtask

   task automatic reset_mid();
      int  k    = 0;
      int  seen = 0;
      bit  prev = 1'b0;
      bit  hit  = 1'b0;
      @(negedge clk); dreq = 1'b1; amount = AMT_W'(300);
      @(negedge clk); dreq = 1'b0;
      while (!hit && k < 100) begin
         if (note_req && !prev) begin
            seen++;
            if (seen == 2) begin
               chk("mid_disp", dispensed, 100);
               rst = 1'b1;
               hit = 1'b1;
            end
         end
         if (!hit) begin
            note_ack = note_req;
            prev = note_req;
            @(negedge clk);
            k++;
         end
      end
      chk("mid_reached", hit, 1);
      note_ack = 1'b0;
      #1;
      chk("rst_outs", {note_req, note_sel, busy, done, reject, jam, low_stock}, 0);
      chk("rst_disp", dispensed, 0);
      @(negedge clk); rst = 1'b0;
      model_reload();
   endtask

`ifdef CASH_DISPENSER_JAM_TIMEOUT_EN
   task automatic jam_test();
      int  k = 0, seen = 0, j0 = 0;
      bit  prev = 1'b0, hit = 1'b0;
      @(negedge clk); dreq = 1'b1; amount = AMT_W'(200);
      @(negedge clk); dreq = 1'b0;
      while (!hit && k < 100) begin
         if (note_req && !prev) begin
            seen++;
            if (seen == 2) j0 = k;
         end
         if (jam) hit = 1'b1;
         else begin
            note_ack = (seen < 2) ? note_req : 1'b0;
            prev = note_req;
            @(negedge clk);
            k++;
         end
      end
      note_ack = 1'b0;
      chk("jam_seen", hit, 1);
      chk("jam_lat", k - j0, TMO);
      chk("jam_outs", {note_req, busy}, 0);
      chk("jam_disp", dispensed, 100);
      mcnt[0] -= 1;
      @(negedge clk); dreq = 1'b1; amount = AMT_W'(100);
      @(negedge clk); dreq = 1'b0;
      chk("jam_reject", reject, 1);
      chk("jam_sticky", jam, 1);
      do_refill();
      chk("jam_clear", jam, 0);
   endtask
`endif

   initial begin
      rst = 1'b1; dreq = 1'b0; amount = '0; refill = 1'b0; note_ack = 1'b0;
      model_reload();
      repeat (3) @(negedge clk);
      chk("reset_outs", {note_req, note_sel, busy, done, reject, jam, low_stock}, 0);
      chk("reset_disp", dispensed, 0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(380, 1'b0);
      run_txn(35, 1'b0);
      run_txn(0, 1'b0);
      run_txn(60, 1'b1);
      run_txn(2000, 1'b0);
      run_txn(700, 1'b0);
      run_txn(400, 1'b0);
      run_txn(180, 1'b0);
      run_txn(80, 1'b0);
      run_txn(10, 1'b0);
      do_refill();
      collide();
      run_txn(120, 1'b0);
      reset_mid();
      run_txn(100, 1'b0);
      run_txn(1000, 1'b0);
`ifdef CASH_DISPENSER_JAM_TIMEOUT_EN
      do_refill();
      jam_test();
      run_txn(100, 1'b0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
